// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data paths; data wins ties unless ARB_ROUND_ROBIN_EN alternates priority.
// Latency: request in IDLE cycle T -> mem_en in T+1 -> ready pulse in T+2+MEM_LATENCY.
// Backpressure: requesters hold req and see *_stall until their one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       owner_d;
  logic       is_wr;
  logic       d_pend;
  logic       grant_d;
  logic       grant_f;
  logic       prio_data;

  assign d_pend   = d_rd | d_wr;
  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_pend & ~d_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_f) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A lone requester is always served, whatever the pointer says.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (state == IDLE) begin
      if (d_pend && (prio_data || !if_req)) grant_d = 1'b1;
      else if (if_req)                      grant_f = 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset)       prio_data <= 1'b1;
    else if (grant_d) prio_data <= 1'b0;
    else if (grant_f) prio_data <= 1'b1;
  end
`else
  assign prio_data = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      cnt       <= '0;
      owner_d   <= 1'b0;
      is_wr     <= 1'b0;
    end else begin
      mem_en   <= grant_d | grant_f;
      mem_we   <= grant_d & d_wr;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant_d) begin
        owner_d   <= 1'b1;
        is_wr     <= d_wr;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_f) begin
        owner_d  <= 1'b0;
        is_wr    <= 1'b0;
        mem_addr <= if_addr;
      end
      if (state == ISSUE)                 cnt <= LAT_M1;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      // Last WAIT cycle: read data is valid now, ready lands in DONE.
      if (state == WAIT && cnt == '0) begin
        if (owner_d) begin
          d_ready <= 1'b1;
          if (!is_wr) d_rdata <= mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at latency 2, plus latency-1 and latency-15 instances.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, d_rd, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we;

  logic        if_req_1, if_req_15;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
  logic [31:0] if_rdata_15, d_rdata_15, mem_addr_15, mem_wdata_15;
  logic        if_ready_1, if_stall_1, d_ready_1, d_stall_1, mem_en_1, mem_we_1;
  logic        if_ready_15, if_stall_15, d_ready_15, d_stall_15, mem_en_15, mem_we_15;
  logic [31:0] zero32 = 32'h0;
  logic        zero1  = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req_1), .if_addr(zero32), .if_rdata(if_rdata_1), .if_ready(if_ready_1), .if_stall(if_stall_1),
    .d_rd(zero1), .d_wr(zero1), .d_addr(zero32), .d_wdata(zero32), .d_rdata(d_rdata_1),
    .d_ready(d_ready_1), .d_stall(d_stall_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(zero32)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset),
    .if_req(if_req_15), .if_addr(zero32), .if_rdata(if_rdata_15), .if_ready(if_ready_15), .if_stall(if_stall_15),
    .d_rd(zero1), .d_wr(zero1), .d_addr(zero32), .d_wdata(zero32), .d_rdata(d_rdata_15),
    .d_ready(d_ready_15), .d_stall(d_stall_15),
    .mem_en(mem_en_15), .mem_we(mem_we_15), .mem_addr(mem_addr_15), .mem_wdata(mem_wdata_15), .mem_rdata(zero32)
  );

  // Memory model for the main instance: data is valid only in the exact cycle two after mem_en.
  logic [3:0]  mcnt = 4'd0;
  logic [31:0] maddr = 32'h0;
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      mcnt  <= 4'd2;
      maddr <= mem_addr;
    end else if (mcnt != 4'd0) begin
      mcnt <= mcnt - 4'd1;
    end
  end
  assign mem_rdata = (mcnt == 4'd1) ? (maddr ^ 32'h8C01_0044) : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int         rdy1, rdy15, en1, en15;
  int         d_cyc, f_cyc, both_hi, ng, n_rdy;
  logic [3:0] pat, exp_pat;

  initial begin
    reset = 1'b0; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; if_req_1 = 1'b0; if_req_15 = 1'b0;
    repeat (3) tick();
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_ready", {30'b0, if_ready, d_ready}, 32'h0);
    check("rst_rdata", if_rdata | d_rdata, 32'h0);
    reset = 1'b1;
    tick();

    // Latency at the extremes
    if_req_1 = 1'b1; if_req_15 = 1'b1;
    rdy1 = -1; rdy15 = -1; en1 = 0; en15 = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (mem_en_1)  en1++;
      if (mem_en_15) en15++;
      if (if_ready_1  && rdy1  < 0) begin rdy1  = c; if_req_1  = 1'b0; end
      if (if_ready_15 && rdy15 < 0) begin rdy15 = c; if_req_15 = 1'b0; end
    end
    check("lat1_ready_cycle", rdy1, 3);
    check("lat15_ready_cycle", rdy15, 17);
    check("lat1_mem_en_count", en1, 1);
    check("lat15_mem_en_count", en15, 1);

    // Store
    d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_mem_en_we", {30'b0, mem_en, mem_we}, 32'h3);
    check("st_mem_addr", mem_addr, 32'h100);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("st_mem_en_c2", {31'b0, mem_en}, 32'h0);
    tick();
    check("st_no_ready_c3", {31'b0, d_ready}, 32'h0);
    tick();
    check("st_d_ready_c4", {31'b0, d_ready}, 32'h1);
    check("st_d_rdata_kept", d_rdata, 32'h0);
    d_wr = 1'b0;
    tick();
    check("st_d_ready_drop", {31'b0, d_ready}, 32'h0);
    check("st_wdata_held", mem_wdata, 32'hDEAD_BEEF);

    // Single fetch
    if_req = 1'b1; if_addr = 32'h40;
    #1 check("f_stall_c0", {31'b0, if_stall}, 32'h1);
    tick();
    check("f_mem_en_c1", {30'b0, mem_en, mem_we}, 32'h2);
    check("f_mem_addr_c1", mem_addr, 32'h40);
    tick();
    check("f_mem_en_c2", {31'b0, mem_en}, 32'h0);
    check("f_stall_c2", {31'b0, if_stall}, 32'h1);
    tick();
    check("f_ready_c3", {31'b0, if_ready}, 32'h0);
    check("f_stall_c3", {31'b0, if_stall}, 32'h1);
    tick();
    check("f_ready_c4", {31'b0, if_ready}, 32'h1);
    check("f_rdata_c4", if_rdata, 32'h8C01_0004);
    check("f_stall_c4", {31'b0, if_stall}, 32'h0);
    if_req = 1'b0;
    tick();
    check("f_ready_drop", {31'b0, if_ready}, 32'h0);
    check("f_rdata_held", if_rdata, 32'h8C01_0004);

    // Simultaneous data read and fetch
    if_req = 1'b1; if_addr = 32'h80; d_rd = 1'b1; d_addr = 32'h200;
    d_cyc = -1; f_cyc = -1; both_hi = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (if_ready && d_ready) both_hi++;
      if (d_ready && d_cyc < 0) begin
        d_cyc = c; d_rd = 1'b0;
        check("sim_d_rdata", d_rdata, 32'h8C01_0244);
      end
      if (if_ready && f_cyc < 0) begin
        f_cyc = c; if_req = 1'b0;
        check("sim_if_rdata", if_rdata, 32'h8C01_00C4);
      end
    end
    check("sim_d_ready_cycle", d_cyc, 4);
    check("sim_if_ready_cycle", f_cyc, 9);
    check("sim_ready_overlap", both_hi, 0);

    // Continuous contention
    d_rd = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h400;
    ng = 0; pat = 4'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_en && ng < 4) begin
        pat[ng] = (mem_addr == 32'h300);
        ng++;
        if (ng == 4) begin d_rd = 1'b0; if_req = 1'b0; end
      end
    end
    check("cont_grants", ng, 4);
    check("cont_pattern", {28'b0, pat}, {28'b0, exp_pat});

    // Reset during WAIT abandons the fetch
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    tick();
    reset = 1'b0; if_req = 1'b0;
    tick();
    reset = 1'b1;
    check("rw_mem_en_we", {30'b0, mem_en, mem_we}, 32'h0);
    check("rw_mem_addr", mem_addr, 32'h0);
    check("rw_mem_wdata", mem_wdata, 32'h0);
    check("rw_rdata", if_rdata | d_rdata, 32'h0);
    check("rw_ready", {30'b0, if_ready, d_ready}, 32'h0);
    n_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_ready || d_ready) n_rdy++;
    end
    check("rw_no_late_ready", n_rdy, 0);
    if_req = 1'b1; if_addr = 32'h48;
    f_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (if_ready && f_cyc < 0) begin
        f_cyc = c; if_req = 1'b0;
        check("rw_refetch_rdata", if_rdata, 32'h8C01_000C);
      end
    end
    check("rw_refetch_cycle", f_cyc, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch path and the data-access path of the 5-stage pipeline.
- Sequences each access as one request, a fixed memory latency, a response capture and then a one-cycle ready pulse.
- Drives the stall signals the pipeline uses to freeze the PC and IF/ID (fetch side) and the whole pipe (data side) while an access is outstanding.
- Sits between the stage logic and the memory macro.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LATENCY, 2, cycles from the cycle in which mem_en is sampled high to the cycle in which mem_rdata is valid. Legal range is 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_ready.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  output  DATA_W  fetched instruction; valid while if_ready is high.
- if_ready  output  1  one-cycle completion pulse for fetch.
- if_stall  output  1  if_req & ~if_ready (combinational).
- d_rd  input  1  data read request; held high until d_ready.
- d_wr  input  1  data write request; held high until d_ready.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load data; valid while d_ready is high.
- d_ready  output  1  one-cycle completion pulse for data.
- d_stall  output  1  (d_rd|d_wr) & ~d_ready (combinational).
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  ADDR_W  registered address.
- mem_wdata  output  DATA_W  registered write data.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All registered outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready.
  - The latency counter goes to 0 and the priority pointer points to the data side.
  - An in-flight access is abandoned. Its mem_rdata is ignored and no ready pulse is ever issued for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: the arbiter samples requests. The grant decision is:
  - Data pending (d_rd|d_wr) and the data side has priority: grant data.
  - Otherwise, if if_req: grant fetch.
  - Otherwise, stay in IDLE.
  - On a grant: latch owner, address, write data and write flag into the mem_* registers, then go to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle. mem_we=1 only for a data write. Counter loads MEM_LATENCY-1, then go to WAIT.
- WAIT: the counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register. Writes capture nothing and leave d_rdata unchanged.
  - Then go to DONE.
- DONE: the owner's ready is 1 for exactly this cycle, then go to IDLE.
  - The requester drops or changes its request on the next cycle.
  - A held request is only resampled in IDLE, so it cannot be double-granted.
- Latency: with the request first high in IDLE cycle T, mem_en is high in T+1 and ready is high in T+2+MEM_LATENCY.
- Throughput: at most one access per MEM_LATENCY+3 cycles.
- Both d_rd and d_wr high: treated as a write.
- Request withdrawn before grant: no access is made. A request withdrawn after grant: the access still completes and the ready pulse is still issued.
- if_rdata and d_rdata hold their last value between accesses.
- mem_addr and mem_wdata hold their value outside ISSUE.
- Only one of if_ready and d_ready can be high in any cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: the priority pointer toggles to the other side after every granted access. When both sides request in IDLE, the side named by the pointer wins. Neither side waits more than one foreign access.
- Undefined: fixed priority, data always beats fetch. The pointer is constant and fetch can starve under back-to-back data requests.

Test Plan:
- Reset mid-WAIT: fetch granted, reset low for 1 cycle during WAIT -> next cycle all outputs 0, state IDLE, no if_ready ever issued for that fetch.
- Single fetch, MEM_LATENCY=2: if_req=1 and if_addr=0x0000_0040 in cycle 0; memory returns 0x8C01_0004 -> mem_en=1 with mem_addr=0x40 in cycle 1, if_ready=1 with if_rdata=0x8C01_0004 in cycle 4, if_stall=1 in cycles 0-3.
- Store: d_wr=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> one cycle with mem_en=mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF; d_ready pulses 3 cycles later; d_rdata unchanged.
- Simultaneous requests: if_req and d_rd both high in IDLE -> data served first, fetch served immediately after. if_ready is never high in the same cycle as d_ready.
- Continuous d_rd plus if_req for 4 accesses: without ARB_ROUND_ROBIN_EN, 4 data grants and 0 fetch grants. With it, grants alternate D,F,D,F.
- MEM_LATENCY=1 and MEM_LATENCY=15: request-to-ready latency is 3 and 17 cycles respectively, and mem_en is high for exactly one cycle per access.
